// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: bubble instruction, default reset vector
// and the fetch sequencer state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: DEPTH entries, first-word fall-through head, synchronous
// clear and reset. Storage is not reset; only pointers and count are.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // A full queue still accepts a word when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop) && !clear;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage write port
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests,
// buffers returned words and presents the head (or a NOP bubble) to IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds saturating bubble/redirect
// counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_En,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic        IMem_Valid,
  input  logic [31:0] IMem_RData,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
  output logic        Fetch_Empty
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Bubble_Count,
  output logic [31:0] Redirect_Count
`endif
);

  // Outstanding can exceed QDEPTH after a redirect (stale words still in
  // flight plus fresh requests), so the counters get generous headroom.
  localparam int CW = 8;
  localparam int OW = $clog2(QDEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] committed;
  logic [OW-1:0] occupancy;
  logic          accept;
  logic          push;
  logic          drop;
  logic          pop;
  logic          q_empty;
  logic          q_full;
  logic [63:0]   q_rdata;

  assign redirect_tgt = Redirect_PC & 32'hFFFF_FFFC;

  // Slots already promised: live in-flight words plus queued words
  assign committed = outstanding - discard + CW'(occupancy);

  assign IMem_Req  = (state != RESET) && !RST && !Redirect_En &&
                     (committed < CW'(QDEPTH));
  assign IMem_Addr = fetch_pc;
  assign accept    = IMem_Req && IMem_Ack;

  assign drop = IMem_Valid && !Redirect_En && (discard != '0);
  assign push = IMem_Valid && !Redirect_En && (discard == '0);
  assign pop  = !Stall_En && !q_empty && !Redirect_En;

  // Next-state and in-flight accounting; redirect overrides everything
  always_comb begin
    state_nxt       = state;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    if (Redirect_En) begin
      outstanding_nxt = outstanding - CW'(IMem_Valid);
      discard_nxt     = outstanding - CW'(IMem_Valid);
    end else begin
      outstanding_nxt = outstanding + CW'(accept) - CW'(IMem_Valid);
      if (drop) discard_nxt = discard - CW'(1);
    end
    unique case (state)
      RESET:      state_nxt = RUN;
      RUN, DRAIN: state_nxt = (discard_nxt != '0) ? DRAIN : RUN;
      default:    state_nxt = RESET;
    endcase
  end

  // Control registers: state, counters, request PC and response PC
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RESET;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (Redirect_En) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (64)
  ) u_queue (
    .CLK   (CLK),
    .RST   (RST),
    .clear (Redirect_En),
    .push  (push),
    .pop   (pop),
    .wdata ({IMem_RData, resp_pc}),
    .rdata (q_rdata),
    .empty (q_empty),
    .full  (q_full),
    .count (occupancy)
  );

  assign Fetch_Empty = q_empty || RST;
  assign Instr_F     = Fetch_Empty ? NOP_INSTR : q_rdata[63:32];
  assign PC_F        = Fetch_Empty ? 32'd0 : q_rdata[31:0];
  assign PC_Plus_4_F = Fetch_Empty ? 32'd0 : q_rdata[31:0] + 32'd4;

  // The issue credit makes an overflowing push impossible
  always @(posedge CLK) begin
    if (!RST) assert (!(push && q_full && !pop));
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating starvation and redirect event counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      Bubble_Count   <= '0;
      Redirect_Count <= '0;
    end else begin
      if (Fetch_Empty && !Stall_En && !Redirect_En && (Bubble_Count != '1))
        Bubble_Count <= Bubble_Count + 32'd1;
      if (Redirect_En && (Redirect_Count != '1))
        Redirect_Count <= Redirect_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests in order,
// a reference stream of expected PCs is reloaded on every reset/redirect,
// and a negedge monitor compares every consumed head and every bubble.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall_En;
  logic        Redirect_En;
  logic [31:0] Redirect_PC;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic        IMem_Valid;
  logic [31:0] IMem_RData;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC_Plus_4_F;
  logic        Fetch_Empty;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] Bubble_Count;
  logic [31:0] Redirect_Count;
`endif

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Stall_En    (Stall_En),
    .Redirect_En (Redirect_En),
    .Redirect_PC (Redirect_PC),
    .IMem_Req    (IMem_Req),
    .IMem_Addr   (IMem_Addr),
    .IMem_Ack    (IMem_Ack),
    .IMem_Valid  (IMem_Valid),
    .IMem_RData  (IMem_RData),
    .Instr_F     (Instr_F),
    .PC_F        (PC_F),
    .PC_Plus_4_F (PC_Plus_4_F),
    .Fetch_Empty (Fetch_Empty)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Bubble_Count   (Bubble_Count),
    .Redirect_Count (Redirect_Count)
`endif
  );

  // Memory image: low addresses hold their own address, others are scrambled
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'h0000_1000) ? a : (a ^ 32'hA5A5_A5A5);
  endfunction

  typedef struct {
    logic [31:0] data;
    int          due;
    int          epoch;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // stimulus-owned knobs
  int lat;
  bit probe_stall;
  bit directed;

  // monitor-owned state
  int          vectors = 0;
  int          miscompares = 0;
  int          epoch = 0;
  int          k = 0;
  bit          prev_redirect = 0;
  logic [31:0] redirect_tgt = '0;
  logic [31:0] exp_req_addr = '0;

  task automatic chk(input string name, input bit ok,
                     input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic reload(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(base + 32'(4 * i));
    exp_req_addr = base;
    epoch++;
  endtask

  // Monitor: compares DUT outputs against the reference stream each cycle
  always @(negedge CLK) begin
    int          live;
    logic [31:0] e;
    logic [31:0] e4;
    mem_t        m;
    if (RST) begin
      chk("reset_req", IMem_Req === 1'b0, {31'd0, IMem_Req}, 32'd0);
      chk("reset_bubble", Fetch_Empty === 1'b1 && Instr_F === NOP_INSTR &&
          PC_F === 32'd0 && PC_Plus_4_F === 32'd0, Instr_F, NOP_INSTR);
      mem_q.delete();
      reload(RPC);
      prev_redirect = 0;
      k = 0;
    end else begin
      if (k == 0)
        chk("post_reset_idle", IMem_Req === 1'b0 && Fetch_Empty === 1'b1,
            {31'd0, IMem_Req}, 32'd0);
      if (directed && k == 1)
        chk("first_req", IMem_Req === 1'b1 && IMem_Addr === RPC, IMem_Addr, RPC);
      if (directed && k == 2)
        chk("first_word_early", Fetch_Empty === 1'b1, {31'd0, Fetch_Empty}, 32'd1);
      if (directed && k >= 3 && k <= 5)
        chk("stream_rate", Fetch_Empty === 1'b0, {31'd0, Fetch_Empty}, 32'd0);

      if (Redirect_En) begin
        chk("req_during_redirect", IMem_Req === 1'b0, {31'd0, IMem_Req}, 32'd0);
        redirect_tgt = {Redirect_PC[31:2], 2'b00};
        reload(redirect_tgt);
        prev_redirect = 1;
      end else begin
        if (prev_redirect)
          chk("redirect_latency", IMem_Req === 1'b1 && IMem_Addr === redirect_tgt,
              IMem_Addr, redirect_tgt);
        prev_redirect = 0;
        if (probe_stall)
          chk("stall_full_no_req", IMem_Req === 1'b0, {31'd0, IMem_Req}, 32'd0);
        if (Fetch_Empty === 1'b1) begin
          chk("bubble_instr", Instr_F === NOP_INSTR, Instr_F, NOP_INSTR);
          chk("bubble_pc", PC_F === 32'd0 && PC_Plus_4_F === 32'd0, PC_F, 32'd0);
        end else if (!Stall_En) begin
          if (exp_q.size() == 0) begin
            chk("exp_overrun", 1'b0, PC_F, 32'd0);
          end else begin
            e  = exp_q.pop_front();
            e4 = e + 32'd4;
            chk("head_pc", PC_F === e, PC_F, e);
            chk("head_instr", Instr_F === mem_word(e), Instr_F, mem_word(e));
            chk("head_pc_plus_4", PC_Plus_4_F === e4, PC_Plus_4_F, e4);
          end
        end
      end

      if (IMem_Req === 1'b1 && IMem_Ack) begin
        chk("req_addr", IMem_Addr === exp_req_addr, IMem_Addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        m.data  = mem_word(IMem_Addr);
        m.due   = cyc + lat;
        m.epoch = epoch;
        mem_q.push_back(m);
      end

      live = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch == epoch) live++;
      chk("inflight_bound", live <= QD, 32'(live), 32'(QD));

      if (IMem_Valid && mem_q.size() > 0) void'(mem_q.pop_front());
      k++;
    end
  end

  // Advance one cycle and present the memory response due this cycle
  task automatic step();
    @(posedge CLK);
    #1;
    if (!RST && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      IMem_Valid = 1'b1;
      IMem_RData = mem_q[0].data;
    end else begin
      IMem_Valid = 1'b0;
      IMem_RData = $urandom;
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    step();
    Redirect_En = 1'b1;
    Redirect_PC = tgt;
    step();
    Redirect_En = 1'b0;
  endtask

  initial begin
    RST = 1'b1; Stall_En = 1'b0; Redirect_En = 1'b0; Redirect_PC = '0;
    IMem_Ack = 1'b1; IMem_Valid = 1'b0; IMem_RData = '0;
    lat = 1; probe_stall = 0; directed = 1;

    // reset, then zero-wait stream from RESET_PC
    repeat (3) step();
    RST = 1'b0;
    repeat (7) step();

    // stall with the queue filling up, then resume
    for (int i = 0; i < 5; i++) begin
      step();
      Stall_En    = 1'b1;
      probe_stall = (i == 4);
    end
    step();
    Stall_En = 1'b0; probe_stall = 0; directed = 0;
    repeat (6) step();

    // three-cycle memory latency, then redirect with words in flight
    lat = 3;
    repeat (20) step();
    redirect(32'h0000_0103);
    repeat (15) step();

    // back-to-back redirects
    step();
    Redirect_En = 1'b1; Redirect_PC = 32'h0000_0200;
    step();
    Redirect_PC = 32'h0000_0300;
    step();
    Redirect_En = 1'b0;
    repeat (15) step();

    // PC wrap at the top of the address space
    lat = 1;
    redirect(32'hFFFF_FFF8);
    repeat (10) step();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step();
      lat         = int'($urandom_range(1, 4));
      IMem_Ack    = ($urandom_range(0, 9) < 7);
      Stall_En    = ($urandom_range(0, 9) < 3);
      Redirect_En = ($urandom_range(0, 19) == 0) || (i % 100 == 99);
      Redirect_PC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
    end
    step();
    Redirect_En = 1'b0; Stall_En = 1'b0; IMem_Ack = 1'b1;
    repeat (10) step();

    // reset in mid-operation, then the zero-wait startup again
    lat = 1; directed = 1;
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    repeat (12) step();
    directed = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
